// File: rtl/fpu_pkg.sv
// Shared constants and types for the fadd arbiter: default latency/depth,
// requester count and the in-flight tag carried alongside each fadd operation.
package fpu_pkg;
    localparam int FADD_LAT_DEFAULT  = 2;
    localparam int RES_DEPTH_DEFAULT = 4;
    localparam int NREQ              = 2;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    function automatic logic [32:0] pack_result(input logic ovf, input logic [31:0] d);
        return {ovf, d};
    endfunction
endpackage

// File: rtl/fadd_arb_fifo.sv
// First-word-fall-through result FIFO holding {ovf, d}; the head is visible
// whenever the FIFO is non-empty and a push+pop when full keeps occupancy constant.
module fadd_arb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH_DEFAULT,
    parameter int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [32:0]   push_data,
    input  logic          pop,
    output logic          valid,
    output logic [32:0]   head,
    output logic [OW-1:0] occupancy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [32:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [OW-1:0] count_r;
    logic          empty_s;
    logic          full_s;
    logic          do_pop_s;
    logic          do_push_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign empty_s   = (count_r == {OW{1'b0}});
    assign full_s    = (count_r == OW'(DEPTH));
    assign do_pop_s  = pop & ~empty_s;
    // When full, the slot being written is the head that is popped this same cycle.
    assign do_push_s = push & (~full_s | do_pop_s);

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {OW{1'b0}};
        end else begin
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + OW'(1);
                2'b01:   count_r <= count_r - OW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign valid     = ~empty_s;
    assign head      = empty_s ? 33'd0 : mem_r[rd_ptr_r];
    assign occupancy = count_r;

    fadd_arb_fifo_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .full (full_s),
        .pop  (do_pop_s)
    );
endmodule

// File: rtl/fadd_arb_fifo_chk.sv
// Checker for one result FIFO: a push may only land on a full FIFO when a pop frees the slot.
module fadd_arb_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full,
    input logic pop
);
    no_push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/fadd_arbiter.sv
// Credit-based round-robin arbiter sharing one external fadd unit between two
// requesters, with a tag pipeline steering each result into its requester's FIFO.
module fadd_arbiter
    import fpu_pkg::*;
#(
    parameter int FADD_LAT  = FADD_LAT_DEFAULT,
    parameter int RES_DEPTH = RES_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_s,
    input  logic [31:0] req0_t,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_s,
    input  logic [31:0] req1_t,
    output logic [31:0] fadd_s,
    output logic [31:0] fadd_t,
    input  logic [31:0] fadd_d,
    input  logic        fadd_ovf,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_d,
    output logic        res0_ovf,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_d,
    output logic        res1_ovf,
    output logic        busy
);
    localparam int OW = $clog2(RES_DEPTH + 1);
    localparam int CW = $clog2(RES_DEPTH + FADD_LAT + 1) + 1;

    tag_t            tag_r [FADD_LAT];
    logic            ptr_r;
    logic [OW-1:0]   occ0_s;
    logic [OW-1:0]   occ1_s;
    logic [CW-1:0]   flight0_s;
    logic [CW-1:0]   flight1_s;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] push_s;
    logic [32:0]     head0_s;
    logic [32:0]     head1_s;
    logic [32:0]     result_s;
    tag_t            new_tag_s;
    tag_t            end_tag_s;
    logic            busy_s;

    // In-flight operations per requester, counted from the tag pipeline.
    always_comb begin
        flight0_s = {CW{1'b0}};
        flight1_s = {CW{1'b0}};
        for (int i = 0; i < FADD_LAT; i++) begin
            flight0_s = flight0_s + CW'(tag_r[i].valid & ~tag_r[i].id);
            flight1_s = flight1_s + CW'(tag_r[i].valid & tag_r[i].id);
        end
    end

    // Eligibility from registered credit, then round-robin pick of at most one requester.
    always_comb begin
        elig_s[0]  = req0_valid & ~rst & ((CW'(occ0_s) + flight0_s) < CW'(RES_DEPTH));
        elig_s[1]  = req1_valid & ~rst & ((CW'(occ1_s) + flight1_s) < CW'(RES_DEPTH));
        grant_s[0] = elig_s[0] & (~elig_s[1] | ~ptr_r);
        grant_s[1] = elig_s[1] & (~elig_s[0] | ptr_r);
    end

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Operand mux towards the shared unit; zero when idle.
    always_comb begin
        if (grant_s[0]) begin
            fadd_s = req0_s;
            fadd_t = req0_t;
        end else if (grant_s[1]) begin
            fadd_s = req1_s;
            fadd_t = req1_t;
        end else begin
            fadd_s = 32'd0;
            fadd_t = 32'd0;
        end
        new_tag_s.valid = grant_s[0] | grant_s[1];
        new_tag_s.id    = grant_s[1];
    end

    // Round-robin pointer: hand priority to the other requester after each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (grant_s[0]) begin
            ptr_r <= 1'b1;
        end else if (grant_s[1]) begin
            ptr_r <= 1'b0;
        end
    end

    // Tag pipeline aligned with the fadd latency; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FADD_LAT; i++) tag_r[i] <= tag_t'(2'b00);
        end else begin
            tag_r[0] <= new_tag_s;
            for (int i = 1; i < FADD_LAT; i++) tag_r[i] <= tag_r[i-1];
        end
    end

    assign end_tag_s = tag_r[FADD_LAT-1];
    assign push_s[0] = end_tag_s.valid & ~end_tag_s.id;
    assign push_s[1] = end_tag_s.valid & end_tag_s.id;
    assign result_s  = pack_result(fadd_ovf, fadd_d);

    fadd_arb_fifo #(.DEPTH(RES_DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s[0]),
        .push_data (result_s),
        .pop       (res0_ready),
        .valid     (res0_valid),
        .head      (head0_s),
        .occupancy (occ0_s)
    );

    fadd_arb_fifo #(.DEPTH(RES_DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s[1]),
        .push_data (result_s),
        .pop       (res1_ready),
        .valid     (res1_valid),
        .head      (head1_s),
        .occupancy (occ1_s)
    );

    assign res0_d   = head0_s[31:0];
    assign res0_ovf = head0_s[32];
    assign res1_d   = head1_s[31:0];
    assign res1_ovf = head1_s[32];

    // Activity flag built only from registered state.
    always_comb begin
        busy_s = res0_valid | res1_valid;
        for (int i = 0; i < FADD_LAT; i++) busy_s = busy_s | tag_r[i].valid;
    end

    assign busy = busy_s;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench: queue-based reference model checked every cycle, a vector
// table of single issues, directed corner sequences and a FIFO-level full push/pop test.
module tb_fadd_arbiter;
    import fpu_pkg::*;

    localparam int LAT   = FADD_LAT_DEFAULT;
    localparam int DEPTH = RES_DEPTH_DEFAULT;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_s, req0_t, req1_s, req1_t;
    logic [31:0] fadd_s, fadd_t, fadd_d;
    logic        fadd_ovf;
    logic        res0_valid, res0_ready, res0_ovf, res1_valid, res1_ready, res1_ovf;
    logic [31:0] res0_d, res1_d;
    logic        busy;

    logic        f_push, f_pop, f_valid;
    logic [32:0] f_din, f_head;
    logic [2:0]  f_occ;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fadd_arbiter #(.FADD_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s(req0_s), .req0_t(req0_t),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s(req1_s), .req1_t(req1_t),
        .fadd_s(fadd_s), .fadd_t(fadd_t), .fadd_d(fadd_d), .fadd_ovf(fadd_ovf),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_d(res0_d), .res0_ovf(res0_ovf),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_d(res1_d), .res1_ovf(res1_ovf),
        .busy(busy)
    );

    fadd_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(f_push), .push_data(f_din), .pop(f_pop),
        .valid(f_valid), .head(f_head), .occupancy(f_occ)
    );

    // Stand-in fadd unit: exact IEEE sums for the known operand pairs, a scrambler otherwise.
    function automatic logic [32:0] fadd_unit(input logic [31:0] s, input logic [31:0] t);
        case ({s, t})
            64'h3F800000_40000000: return {1'b0, 32'h40400000};
            64'h7F7FFFFF_7F7FFFFF: return {1'b1, 32'h7F800000};
            64'h40000000_40000000: return {1'b0, 32'h40800000};
            64'h3F800000_3F800000: return {1'b0, 32'h40000000};
            64'h40400000_3F800000: return {1'b0, 32'h40800000};
            64'hBF800000_3F800000: return {1'b0, 32'h00000000};
            64'h41200000_40A00000: return {1'b0, 32'h41700000};
            default:               return {^(s ^ t), s ^ {t[15:0], t[31:16]} ^ 32'h5A5A0F0F};
        endcase
    endfunction

    logic [32:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= fadd_unit(fadd_s, fadd_t);
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fadd_d   = fpipe[LAT-1][31:0];
    assign fadd_ovf = fpipe[LAT-1][32];

    // ---------------- reference model ----------------
    typedef struct { int id; logic [32:0] r; int due; } flight_t;
    flight_t     flight_q[$];
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          favour = 0;
    int          cyc = 0;
    int          g = -1;
    int          checks = 0;
    int          errors = 0;
    logic        samp_rdy [2];
    logic        samp_rv  [2];
    logic [32:0] samp_res [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int in_flight(input int id);
        int n = 0;
        foreach (flight_q[i]) if (flight_q[i].id == id) n++;
        return n;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit      e0, e1, p0, p1;
        flight_t f;
        @(negedge clk);
        samp_rdy[0] = req0_ready;  samp_rdy[1] = req1_ready;
        samp_rv[0]  = res0_valid;  samp_rv[1]  = res1_valid;
        samp_res[0] = {res0_ovf, res0_d};
        samp_res[1] = {res1_ovf, res1_d};
        if (rst) begin
            g = -1;
            chk("rst_ready", {req0_ready, req1_ready}, 64'd0);
            chk("rst_fadd_ops", {fadd_s, fadd_t}, 64'd0);
            chk("rst_res", {res0_valid, res1_valid, res0_ovf, res1_ovf, res0_d, res1_d}, 64'd0);
            chk("rst_busy", busy, 64'd0);
        end else begin
            e0 = req0_valid && (q0.size() + in_flight(0) < DEPTH);
            e1 = req1_valid && (q1.size() + in_flight(1) < DEPTH);
            if (e0 && e1)  g = favour;
            else if (e0)   g = 0;
            else if (e1)   g = 1;
            else           g = -1;
            chk("ready0", req0_ready, g == 0);
            chk("ready1", req1_ready, g == 1);
            chk("fadd_s", fadd_s, (g == 0) ? req0_s : (g == 1) ? req1_s : 32'd0);
            chk("fadd_t", fadd_t, (g == 0) ? req0_t : (g == 1) ? req1_t : 32'd0);
            chk("res0_valid", res0_valid, q0.size() != 0);
            chk("res1_valid", res1_valid, q1.size() != 0);
            if (q0.size() != 0) chk("res0_head", {res0_ovf, res0_d}, q0[0]);
            if (q1.size() != 0) chk("res1_head", {res1_ovf, res1_d}, q1[0]);
            chk("busy", busy, (flight_q.size() != 0) || (q0.size() != 0) || (q1.size() != 0));
        end
        @(posedge clk);
        if (rst) begin
            flight_q.delete(); q0.delete(); q1.delete();
            favour = 0;
        end else begin
            p0 = (q0.size() != 0) && res0_ready;
            p1 = (q1.size() != 0) && res1_ready;
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            while (flight_q.size() != 0 && flight_q[0].due == cyc) begin
                f = flight_q.pop_front();
                if (f.id == 0) q0.push_back(f.r);
                else           q1.push_back(f.r);
            end
            if (g >= 0) begin
                f.id  = g;
                f.r   = (g == 0) ? fadd_unit(req0_s, req0_t) : fadd_unit(req1_s, req1_t);
                f.due = cyc + LAT;
                flight_q.push_back(f);
                favour = 1 - g;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [31:0] s, input logic [31:0] t);
        if (id == 0) begin
            req0_valid = v; req0_s = s; req0_t = t;
        end else begin
            req1_valid = v; req1_s = s; req1_t = t;
        end
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        res0_ready = 1'b1; res1_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct { int id; logic [31:0] s; logic [31:0] t; logic [31:0] d; logic ovf; } vec_t;
    vec_t        vecs [6];
    logic [32:0] fv [5];

    initial begin
        int          lat, g1cnt, stale, cnt0, cnt1;
        logic [32:0] got;

        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1] = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
        vecs[2] = '{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
        vecs[3] = '{1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0};
        vecs[4] = '{0, 32'hBF800000, 32'h3F800000, 32'h00000000, 1'b0};
        vecs[5] = '{1, 32'h41200000, 32'h40A00000, 32'h41700000, 1'b0};
        fv[0] = 33'h1_00000001; fv[1] = 33'h0_12345678; fv[2] = 33'h1_DEADBEEF;
        fv[3] = 33'h0_0BADF00D; fv[4] = 33'h1_CAFE0042;
        f_push = 1'b0; f_pop = 1'b0; f_din = 33'd0;

        do_reset();

        // Single issues from the vector table: latency, value and routing.
        foreach (vecs[i]) begin
            set_req(vecs[i].id, 1'b1, vecs[i].s, vecs[i].t);
            cycle();
            chk("vec_grant", samp_rdy[vecs[i].id], 64'd1);
            set_req(vecs[i].id, 1'b0, 32'd0, 32'd0);
            lat = -1; got = 33'd0;
            for (int k = 1; k <= 8; k++) begin
                cycle();
                if (lat < 0 && samp_rv[vecs[i].id]) begin
                    lat = k; got = samp_res[vecs[i].id];
                end
            end
            chk("vec_latency", lat, LAT + 1);
            chk("vec_result", got, {vecs[i].ovf, vecs[i].d});
        end

        // Contention: strict alternation starting with requester 0.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_req(0, 1'b1, $urandom(), $urandom());
            set_req(1, 1'b1, $urandom(), $urandom());
            cycle();
            chk("alt_ready0", samp_rdy[0], (i % 2) == 0);
            chk("alt_ready1", samp_rdy[1], (i % 2) == 1);
        end

        // Backpressure on requester 1: four credits, then only a pop re-enables it.
        do_reset();
        res1_ready = 1'b0;
        g1cnt = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(0, 1'b1, $urandom(), $urandom());
            set_req(1, 1'b1, $urandom(), $urandom());
            cycle();
            if (samp_rdy[1]) g1cnt++;
            if (i >= 10) begin
                chk("bp_req1_blocked", samp_rdy[1], 64'd0);
                chk("bp_req0_flows", samp_rdy[0], 64'd1);
            end
        end
        chk("bp_req1_grants", g1cnt, 4);
        res1_ready = 1'b1;
        cycle();
        chk("bp_pop_cycle_ready1", samp_rdy[1], 64'd0);
        res1_ready = 1'b0;
        cycle();
        chk("bp_after_pop_ready1", samp_rdy[1], 64'd1);
        cycle();
        chk("bp_credit_gone_ready1", samp_rdy[1], 64'd0);

        // Reset with two operations in flight.
        do_reset();
        set_req(0, 1'b1, 32'h40000000, 32'h40000000);
        cycle();
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b1, 32'h3F800000, 32'h3F800000);
        cycle();
        set_req(1, 1'b0, 32'd0, 32'd0);
        cycle();
        rst = 1'b1;
        #1;
        chk("async_rst_res", {res0_valid, res1_valid, res0_ovf, res1_ovf, res0_d, res1_d}, 64'd0);
        chk("async_rst_busy", busy, 64'd0);
        cycle();
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            cycle();
            if (samp_rv[0] || samp_rv[1]) stale++;
        end
        chk("rst_stale_results", stale, 0);
        chk("rst_idle_busy", busy, 64'd0);
        set_req(0, 1'b1, 32'h40400000, 32'h3F800000);
        cycle();
        set_req(0, 1'b0, 32'd0, 32'd0);
        cnt0 = 0; cnt1 = 0; got = 33'd0;
        for (int k = 0; k < LAT + 4; k++) begin
            cycle();
            if (samp_rv[0]) begin cnt0++; got = samp_res[0]; end
            if (samp_rv[1]) cnt1++;
        end
        chk("post_rst_count0", cnt0, 1);
        chk("post_rst_count1", cnt1, 0);
        chk("post_rst_result", got, {1'b0, 32'h40800000});

        // Randomised traffic with random result backpressure.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_req(0, $urandom_range(0, 3) != 0, $urandom(), $urandom());
            if ($urandom_range(0, 7) == 0) set_req(1, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF);
            else                           set_req(1, $urandom_range(0, 3) != 0, $urandom(), $urandom());
            res0_ready = $urandom_range(0, 3) != 0;
            res1_ready = $urandom_range(0, 2) != 0;
            cycle();
        end
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        res0_ready = 1'b1; res1_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        chk("drain_busy", busy, 64'd0);

        // Result FIFO full with simultaneous push and pop.
        for (int k = 0; k < 4; k++) begin
            f_push = 1'b1; f_din = fv[k];
            cycle();
        end
        chk("fifo_occ_full", f_occ, 64'd4);
        chk("fifo_head_first", f_head, fv[0]);
        f_push = 1'b1; f_din = fv[4]; f_pop = 1'b1;
        cycle();
        chk("fifo_occ_pushpop", f_occ, 64'd4);
        f_push = 1'b0;
        for (int k = 1; k < 5; k++) begin
            chk("fifo_order", {f_valid, f_head}, {1'b1, fv[k]});
            cycle();
        end
        f_pop = 1'b0;
        chk("fifo_empty", {f_valid, f_occ}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
